// File: rtl/apb_seq_pkg.sv
// Shared types and default sizing for the APB command sequencer.
package apb_seq_pkg;

  localparam int unsigned AddrWDef      = 32;
  localparam int unsigned DataWDef      = 32;
  localparam int unsigned DepthDef      = 4;
  localparam int unsigned TimeoutCycDef = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } seq_state_e;

  typedef struct packed {
    logic                write;
    logic [AddrWDef-1:0] addr;
    logic [DataWDef-1:0] wdata;
  } cmd_t;

  // Flattened command width: {write, addr, wdata}, same layout as cmd_t.
  function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/apb_seq_fifo.sv
// Synchronous command FIFO with occupancy count; Depth must be a power of two.
module apb_seq_fifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Queues APB read/write commands and issues them one at a time to apb_master.
// Optional WAIT-state timeout enabled by defining APB_SEQ_TIMEOUT_EN.
module apb_cmd_sequencer
  import apb_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = AddrWDef,
  parameter int unsigned DATA_W      = DataWDef,
  parameter int unsigned DEPTH       = DepthDef,
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDef
) (
  input  logic                     pclk_i,
  input  logic                     presetn_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_write_i,
  input  logic [ADDR_W-1:0]        cmd_addr_i,
  input  logic [DATA_W-1:0]        cmd_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_write_o,
  output logic [DATA_W-1:0]        rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     pwrite_master_o,
  output logic [ADDR_W-1:0]        paddr_master_o,
  output logic [DATA_W-1:0]        pwdata_master_o,
  output logic                     xfer_start_o,
  input  logic                     penable_i,
  input  logic                     pready_i,
  input  logic [DATA_W-1:0]        prdata_master_i,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int unsigned CmdW = cmd_width(ADDR_W, DATA_W);

  seq_state_e          state_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                xfer_start_q;
  logic                rsp_valid_q;
  logic                rsp_write_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  logic [CmdW-1:0]     fifo_wdata;
  logic [CmdW-1:0]     fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic                xfer_done;

  assign fifo_wdata = {cmd_write_i, cmd_addr_i, cmd_wdata_i};
  assign fifo_pop   = (state_q == StIdle) && !fifo_empty;
  assign xfer_done  = penable_i && pready_i;

  apb_seq_fifo #(
    .Width (CmdW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (pclk_i),
    .rst_ni  (presetn_i),
    .push_i  (cmd_valid_i),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

`ifdef APB_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q;
  logic            tmo_hit;

  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      tmo_q <= '0;
    end else if (state_q == StIssue) begin
      tmo_q <= '0;
    end else if (state_q == StWait && !tmo_hit) begin
      tmo_q <= tmo_q + TmoW'(1);
    end
  end
`else
  logic tmo_hit;
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q      <= StIdle;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      xfer_start_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      xfer_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            pwrite_q <= fifo_head[CmdW-1];
            paddr_q  <= fifo_head[CmdW-2 -: ADDR_W];
            pwdata_q <= fifo_head[DATA_W-1:0];
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          xfer_start_q <= 1'b1;
          state_q      <= StWait;
        end
        StWait: begin
          // A completion landing on the timeout cycle takes priority.
          if (xfer_done) begin
            rsp_valid_q <= 1'b1;
            rsp_write_q <= pwrite_q;
            rsp_rdata_q <= pwrite_q ? '0 : prdata_master_i;
            rsp_err_q   <= 1'b0;
            state_q     <= StResp;
          end else if (tmo_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_write_q <= pwrite_q;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o     = !fifo_full;
  assign busy_o          = (state_q != StIdle) || !fifo_empty;
  assign pwrite_master_o = pwrite_q;
  assign paddr_master_o  = paddr_q;
  assign pwdata_master_o = pwdata_q;
  assign xfer_start_o    = xfer_start_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_write_o     = rsp_write_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_err_o       = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Randomised bench for apb_cmd_sequencer with an APB bus/slave model and an
// in-order response scoreboard built from a simple register-file model.
module tb_apb_cmd_sequencer;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic                   clk = 1'b0;
  logic                   presetn;
  logic                   cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]          cmd_addr;
  logic [DW-1:0]          cmd_wdata;
  logic                   rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [DW-1:0]          rsp_rdata;
  logic                   pwrite;
  logic [AW-1:0]          paddr;
  logic [DW-1:0]          pwdata;
  logic                   xfer_start, penable, pready, busy;
  logic [DW-1:0]          prdata;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 clk = ~clk;

  apb_cmd_sequencer #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .pclk_i          (clk),
    .presetn_i       (presetn),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_write_i     (cmd_write),
    .cmd_addr_i      (cmd_addr),
    .cmd_wdata_i     (cmd_wdata),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_write_o     (rsp_write),
    .rsp_rdata_o     (rsp_rdata),
    .rsp_err_o       (rsp_err),
    .pwrite_master_o (pwrite),
    .paddr_master_o  (paddr),
    .pwdata_master_o (pwdata),
    .xfer_start_o    (xfer_start),
    .penable_i       (penable),
    .pready_i        (pready),
    .prdata_master_i (prdata),
    .busy_o          (busy),
    .fifo_count_o    (fifo_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: register file updated in command order.
  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } req_t;
  typedef struct { logic w; logic [DW-1:0] rd; logic err; } rsp_t;

  logic [DW-1:0] mem_model [logic [AW-1:0]];
  logic [DW-1:0] slv_mem   [logic [AW-1:0]];
  req_t          req_q[$];
  rsp_t          rsp_q[$];

  int cyc = 0;
  int accept_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic terr);
    int   t = 0;
    req_t q;
    rsp_t r;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    while (!cmd_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      check("push_accept_bound", cmd_ready, 1'b1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    accept_cyc = cyc;
    q.w = w; q.a = a; q.d = d;
    req_q.push_back(q);
    if (terr) begin
      r.w = w; r.rd = '0; r.err = 1'b1;
    end else if (w) begin
      mem_model[a] = d;
      r.w = 1'b1; r.rd = '0; r.err = 1'b0;
    end else begin
      r.w = 1'b0; r.rd = mem_model.exists(a) ? mem_model[a] : '0; r.err = 1'b0;
    end
    rsp_q.push_back(r);
  endtask

  // Bus + slave model: setup cycle, then access phase with random wait states.
  logic stall_next = 1'b0;

  task automatic bus_xfer();
    int            n;
    int            t = 0;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = pwrite; a = paddr; d = pwdata;
    @(posedge clk); #1;
    if (!presetn) return;
    penable = 1'b1;
    pready  = 1'b0;
    if (stall_next) begin
      stall_next = 1'b0;
      while (presetn && !rsp_valid && t < 64) begin
        @(posedge clk); #1;
        t++;
      end
      penable = 1'b0;
      return;
    end
    n = $urandom_range(0, 3);
    repeat (n) begin @(posedge clk); #1; end
    pready = 1'b1;
    if (w) begin
      slv_mem[a] = d;
      prdata = $urandom;
    end else begin
      prdata = slv_mem.exists(a) ? slv_mem[a] : '0;
    end
    @(posedge clk); #1;
    penable = 1'b0;
    pready  = 1'b0;
    prdata  = $urandom;
  endtask

  initial begin
    penable = 1'b0;
    pready  = 1'b0;
    prdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (presetn === 1'b1 && xfer_start) bus_xfer();
    end
  end

  logic rsp_rand = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rsp_rand) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: request contents at xfer_start, response order/contents, stability.
  int          xfer_cnt = 0;
  int          rsp_cnt = 0;
  int          last_xfer_cyc = 0;
  int          err_lat = -1;
  logic        prev_xfer = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0, prev_done = 1'b0;
  logic [DW+1:0] held = '0;
  req_t        mon_req;
  rsp_t        mon_rsp;

  always @(negedge clk) begin
    if (presetn !== 1'b1) begin
      prev_xfer = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0; prev_done = 1'b0;
    end else begin
      if (xfer_start) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        check("xfer_pulse_single", prev_xfer, 1'b0);
        if (req_q.size() == 0) begin
          check("xfer_unexpected", xfer_start, 1'b0);
        end else begin
          mon_req = req_q.pop_front();
          check("req_pwrite", pwrite, mon_req.w);
          check("req_paddr", paddr, mon_req.a);
          check("req_pwdata", pwdata, mon_req.d);
        end
      end
      if (prev_done) check("rsp_valid_after_done", rsp_valid, 1'b1);
      if (rsp_valid && !prev_rv && rsp_err) err_lat = cyc - last_xfer_cyc;
      if (rsp_valid && prev_rv && !prev_rr)
        check("rsp_stable", {rsp_write, rsp_err, rsp_rdata}, held);
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          mon_rsp = rsp_q.pop_front();
          check("rsp_write", rsp_write, mon_rsp.w);
          check("rsp_rdata", rsp_rdata, mon_rsp.rd);
          check("rsp_err", rsp_err, mon_rsp.err);
        end
      end
      prev_xfer = xfer_start;
      prev_rv   = rsp_valid;
      prev_rr   = rsp_ready;
      prev_done = penable && pready;
      held      = {rsp_write, rsp_err, rsp_rdata};
    end
  end

  task automatic wait_drain();
    int t = 0;
    while ((rsp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_rsp_left", rsp_q.size(), 0);
    check("drain_busy", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  int x0, r0, a1, t;

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    presetn   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_xfer_start", xfer_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_paddr", paddr, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 1'b0);
    presetn = 1'b1;
    @(posedge clk); #1;

    // Single write, latency to xfer_start.
    push_cmd(1'b1, 32'h0, 32'd24, 1'b0);
    a1 = accept_cyc;
    wait_drain();
    check("t1_xfer_latency", last_xfer_cyc - a1, 2);
    check("t1_xfer_count", xfer_cnt, 1);

    // Back-to-back writes then read-back.
    push_cmd(1'b1, 32'h4, 32'h13122023, 1'b0);
    push_cmd(1'b1, 32'h8, 32'h53686B61, 1'b0);
    push_cmd(1'b1, 32'hC, 32'h44656E69, 1'b0);
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 32'(i * 4), '0, 1'b0);
    wait_drain();
    check("t2_rsp_count", rsp_cnt, 8);

    // Fill with responses blocked; hold RESP for a while.
    rsp_ready = 1'b0;
    x0 = xfer_cnt;
    for (int i = 0; i <= DEPTH; i++) push_cmd(1'b1, 32'(32'h40 + i * 4), $urandom, 1'b0);
    repeat (10) @(negedge clk);
    check("t3_fifo_full_count", fifo_count, DEPTH);
    check("t3_cmd_ready_low", cmd_ready, 1'b0);
    check("t4_rsp_valid_held", rsp_valid, 1'b1);
    check("t4_one_in_flight", xfer_cnt - x0, 1);
    repeat (10) @(negedge clk);
    check("t4_no_new_xfer", xfer_cnt - x0, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain();
    check("t3_all_issued", xfer_cnt - x0, DEPTH + 1);

    // Reset while waiting on a stalled transfer with three queued.
    stall_next = 1'b1;
    x0 = xfer_cnt;
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 32'(i * 4), '0, 1'b0);
    t = 0;
    while (xfer_cnt == x0 && t < 50) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1;
    check("t5_pre_count", fifo_count, 3);
    check("t5_pre_busy", busy, 1'b1);
    presetn = 1'b0;
    #1;
    check("t5_busy", busy, 1'b0);
    check("t5_count", fifo_count, 0);
    check("t5_rsp_valid", rsp_valid, 1'b0);
    check("t5_cmd_ready", cmd_ready, 1'b1);
    req_q.delete();
    rsp_q.delete();
    r0 = rsp_cnt;
    @(posedge clk); #1;
    presetn = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_no_xfer_after", xfer_cnt - x0, 1);
    check("t5_no_rsp_after", rsp_cnt - r0, 0);
    check("t5_idle_after", busy, 1'b0);
    @(posedge clk); #1;

    // Randomised traffic with random response back-pressure.
    rsp_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 4), $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_drain();
    rsp_rand  = 1'b0;
    rsp_ready = 1'b1;

`ifdef APB_SEQ_TIMEOUT_EN
    stall_next = 1'b1;
    push_cmd(1'b0, 32'h20, '0, 1'b1);
    push_cmd(1'b0, 32'h4, '0, 1'b0);
    wait_drain();
    check("t6_timeout_latency", err_lat, TMO);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
